// File: rtl/samplerz_pkg.sv
// Shared definitions for the SamplerZ random-data path: word widths and
// the packed random word type handed from the feeder to the base sampler.
package samplerz_pkg;

    localparam int RDM_W  = 144;                 // served random word width
    localparam int PRNG_W = 64;                  // PRNG output word width
    localparam int ACC_W  = RDM_W + PRNG_W;      // 208: worst-case accumulator fill
    localparam int CNT_W  = 8;                   // accumulator bit count, 0..207

    typedef logic [RDM_W-1:0] rdm_word_t;

endpackage

// File: rtl/rdm_feeder_fifo.sv
// rdm_fifo: small synchronous FIFO of packed random words.
// Pointers carry one extra wrap bit so full and empty are told apart without
// the occupancy register; the occupancy is kept registered for the level port.
// Storage is never reset: only the pointers and the count qualify its contents.
module rdm_fifo
    import samplerz_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  rdm_word_t       din,
    output rdm_word_t       dout,
    output logic [LW-1:0]   level,
    output logic            full,
    output logic            empty
);

    rdm_word_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Qualify requests: pop needs data, push needs room or a same-cycle pop.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty && !flush;
        do_push = push && (!full || do_pop) && !flush;
        dout    = mem[rd_ptr[AW-1:0]];
    end

    // Pointer and occupancy update; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    // Word storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rdm_feeder.sv
// rdm_feeder: packs a 64-bit PRNG stream into 144-bit words, prefetches them
// in rdm_fifo and serves one word per rdm_req on the registered rdm144 port.
// Oldest input bits land in the LSBs of each packed word.
// Optional build macro RDM_FEEDER_STATS_EN adds saturating served/underflow
// counters (served_cnt, underflow_cnt); without it those ports do not exist.
module rdm_feeder
    import samplerz_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = 64,
    parameter int OUT_W = 144,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rdm_req,
    output logic [OUT_W-1:0]  rdm144,
    output logic              rdm_rdy,
    output logic [LW-1:0]     level,
    output logic              underflow
`ifdef RDM_FEEDER_STATS_EN
    ,
    output logic [31:0]       served_cnt,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam logic [CNT_W-1:0] PACK_BITS = CNT_W'(RDM_W);
    localparam logic [CNT_W-1:0] IN_BITS   = CNT_W'(PRNG_W);

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_cnt;
    logic [ACC_W-1:0]  acc_sh;
    logic [CNT_W-1:0]  cnt_sh;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              xfer;
    logic              pack;
    logic              pop;
    logic              req_empty;
    rdm_word_t         head;
    logic              fifo_full;
    logic              fifo_empty;

    rdm_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (pack),
        .pop   (pop),
        .din   (acc[RDM_W-1:0]),
        .dout  (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Event decode; flush suppresses every transfer, pack and pop.
    always_comb begin
        in_ready  = (acc_cnt <= PACK_BITS - 1'b1);
        rdm_rdy   = (level != '0);
        pop       = rdm_req && !fifo_empty && !flush;
        req_empty = rdm_req && fifo_empty && !flush;
        xfer      = in_valid && in_ready && !flush;
        pack      = (acc_cnt >= PACK_BITS) && (!fifo_full || pop) && !flush;
    end

    // Next accumulator: retire a packed word first, then append the new input
    // right above the bits that remain, so both events see the pre-edge count.
    always_comb begin
        acc_sh  = pack ? (acc >> RDM_W) : acc;
        cnt_sh  = pack ? (acc_cnt - PACK_BITS) : acc_cnt;
        acc_nxt = acc_sh;
        cnt_nxt = cnt_sh;
        if (xfer) begin
            acc_nxt = acc_sh | (ACC_W'(in_data) << cnt_sh);
            cnt_nxt = cnt_sh + IN_BITS;
        end
    end

    // Accumulator register; bits above acc_cnt are kept zero so appends can OR in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (flush) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            acc     <= acc_nxt;
            acc_cnt <= cnt_nxt;
        end
    end

    // Served word register: loads the FIFO head on a served request, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rdm144 <= '0;
        else if (pop) rdm144 <= OUT_W'(head);
    end

    // Sticky underflow flag, cleared only by flush or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         underflow <= 1'b0;
        else if (flush)     underflow <= 1'b0;
        else if (req_empty) underflow <= 1'b1;
    end

`ifdef RDM_FEEDER_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Saturating event counters, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_cnt    <= '0;
            underflow_cnt <= '0;
        end else if (flush) begin
            served_cnt    <= '0;
            underflow_cnt <= '0;
        end else begin
            if (pop)       served_cnt    <= sat_inc32(served_cnt);
            if (req_empty) underflow_cnt <= sat_inc16(underflow_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rdm_feeder.sv
// Directed bench for rdm_feeder: packing order, FIFO fill/drain, full-FIFO
// pop+push, underflow and flush behaviour. Inputs change on the falling edge.
module tb_rdm_feeder;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [63:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          rdm_req = 1'b0;
    logic [143:0]  rdm144;
    logic          rdm_rdy;
    logic [2:0]    level;
    logic          underflow;
`ifdef RDM_FEEDER_STATS_EN
    logic [31:0]   served_cnt;
    logic [15:0]   underflow_cnt;
`endif

    int tests = 0;
    int failed = 0;

    logic [63:0]   w [0:40];
    logic [143:0]  p1, p2, p3, p4, p5, p6, p7;
    logic [143:0]  drain [4];

    always #5 clk = ~clk;

    rdm_feeder #(
        .DEPTH (4),
        .IN_W  (64),
        .OUT_W (144)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rdm_req   (rdm_req),
        .rdm144    (rdm144),
        .rdm_rdy   (rdm_rdy),
        .level     (level),
        .underflow (underflow)
`ifdef RDM_FEEDER_STATS_EN
        ,
        .served_cnt    (served_cnt),
        .underflow_cnt (underflow_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until accepted; returns on the falling edge
    // after the accepting rising edge.
    task automatic feed(input logic [63:0] word);
        int n = 0;
        in_data  = word;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("feed_timeout", 208'(n < 20), 208'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic request();
        rdm_req = 1'b1;
        @(negedge clk);
        rdm_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i <= 40; i++) w[i] = {8{8'(i)}};
        p1 = {w[3][15:0],  w[2],  w[1]};
        p2 = {w[5][31:0],  w[4],  w[3][63:16]};
        p3 = {w[7][47:0],  w[6],  w[5][63:32]};
        p4 = {w[9],        w[8],  w[7][63:48]};
        p5 = {w[12][15:0], w[11], w[10]};
        p6 = {w[14][31:0], w[13], w[12][63:16]};
        p7 = {w[32][15:0], w[31], w[30]};
        drain = '{p3, p4, p5, p6};

        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_rdm144",    208'(rdm144),    '0);
        chk("rst_rdm_rdy",   208'(rdm_rdy),   '0);
        chk("rst_in_ready",  208'(in_ready),  208'(1));
        chk("rst_level",     208'(level),     '0);
        chk("rst_underflow", 208'(underflow), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: nine words fill the FIFO exactly
        for (int i = 1; i <= 9; i++) feed(w[i]);
        @(negedge clk);
        chk("fill_level",   208'(level),          208'(4));
        chk("fill_acc_cnt", 208'(dut.acc_cnt),    '0);
        chk("fill_head",    208'(dut.head),       208'(p1));
        chk("fill_rdy",     208'(rdm_rdy),        208'(1));

        // 3: one served request, word held afterwards
        request();
        chk("srv1_rdm144", 208'(rdm144), 208'(p1));
        chk("srv1_level",  208'(level),  208'(3));
        repeat (2) @(negedge clk);
        chk("srv1_hold",   208'(rdm144), 208'(p1));

        // 4: refill to full, then stall with bits pending, then pop+push
        feed(w[10]);
        feed(w[11]);
        feed(w[12]);
        chk("acc192_cnt",   208'(dut.acc_cnt), 208'(192));
        chk("acc192_ready", 208'(in_ready),    '0);
        @(negedge clk);
        chk("refill_level", 208'(level),       208'(4));
        chk("refill_cnt",   208'(dut.acc_cnt), 208'(48));
        feed(w[13]);
        feed(w[14]);
        repeat (2) @(negedge clk);
        chk("full_stall_cnt",   208'(dut.acc_cnt), 208'(176));
        chk("full_stall_ready", 208'(in_ready),    '0);
        chk("full_stall_level", 208'(level),       208'(4));
        request();
        chk("popush_rdm144", 208'(rdm144),      208'(p2));
        chk("popush_level",  208'(level),       208'(4));
        chk("popush_cnt",    208'(dut.acc_cnt), 208'(32));
        chk("popush_ready",  208'(in_ready),    208'(1));

        // 5: drain back to back, then underflow and flush
        rdm_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", k), 208'(rdm144), 208'(drain[k]));
        end
        rdm_req = 1'b0;
        chk("drain_level", 208'(level),     '0);
        chk("drain_rdy",   208'(rdm_rdy),   '0);
        chk("drain_uflow", 208'(underflow), '0);
        request();
        chk("uflow_rdm144", 208'(rdm144),    208'(p6));
        chk("uflow_flag",   208'(underflow), 208'(1));
        repeat (2) @(negedge clk);
        chk("uflow_sticky", 208'(underflow), 208'(1));
`ifdef RDM_FEEDER_STATS_EN
        chk("stat_served",    208'(served_cnt),    208'(6));
        chk("stat_underflow", 208'(underflow_cnt), 208'(1));
`endif
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_uflow",  208'(underflow),   '0);
        chk("flush_level",  208'(level),       '0);
        chk("flush_ready",  208'(in_ready),    208'(1));
        chk("flush_cnt",    208'(dut.acc_cnt), '0);
        chk("flush_rdm144", 208'(rdm144),      208'(p6));
`ifdef RDM_FEEDER_STATS_EN
        chk("flush_stat_served", 208'(served_cnt),    '0);
        chk("flush_stat_uflow",  208'(underflow_cnt), '0);
`endif

        // 6: flush at acc_cnt=128 drops the presented word
        feed(w[20]);
        feed(w[21]);
        chk("pre_flush_cnt", 208'(dut.acc_cnt), 208'(128));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = w[22];
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("drop_cnt",   208'(dut.acc_cnt), '0);
        chk("drop_level", 208'(level),       '0);
        feed(w[30]);
        feed(w[31]);
        feed(w[32]);
        @(negedge clk);
        chk("restart_level", 208'(level), 208'(1));
        request();
        chk("restart_rdm144", 208'(rdm144),    208'(p7));
        chk("restart_uflow",  208'(underflow), '0);
`ifdef RDM_FEEDER_STATS_EN
        chk("restart_stat_served", 208'(served_cnt), 208'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
